// File: rtl/slot_alloc_16.sv
// slot_alloc_16: 16-entry free-slot allocator with LSB-priority grant and single-cycle release
module slot_alloc_16 #(
    parameter logic [15:0] INIT_MAP = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_req,
    input  logic        free_req,
    input  logic [3:0]  free_idx,
    output logic        alloc_ack,
    output logic        alloc_nak,
    output logic [3:0]  alloc_idx,
    output logic        free_err,
    output logic [15:0] busy,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty
);
    localparam logic [4:0] INIT_COUNT = 5'($countones(INIT_MAP));
    logic [3:0] sel;
    logic       alloc_ok;
    logic       free_ok;
    always_comb begin
        sel = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (!busy[i]) sel = 4'(i);
    end
    assign full     = count == 5'd16;
    assign empty    = count == 5'd0;
    assign alloc_ok = alloc_req && !full;
    assign free_ok  = free_req && busy[free_idx];
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= INIT_MAP;
            count     <= INIT_COUNT;
            alloc_ack <= 1'b0;
            alloc_nak <= 1'b0;
            free_err  <= 1'b0;
            alloc_idx <= 4'd0;
        end else begin
            busy      <= (busy | (16'(alloc_ok) << sel)) & ~(16'(free_ok) << free_idx);
            count     <= count + 5'(alloc_ok) - 5'(free_ok);
            alloc_ack <= alloc_ok;
            alloc_nak <= alloc_req && full;
            free_err  <= free_req && !busy[free_idx];
            if (alloc_ok) alloc_idx <= sel;
        end
    end
endmodule

// File: tb/tb_slot_alloc_16.sv
// tb_slot_alloc_16: scoreboard bench for slot_alloc_16 with directed and random steps
module tb_slot_alloc_16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_req = 1'b0;
    logic        free_req = 1'b0;
    logic [3:0]  free_idx = 4'd0;
    logic        ack, nak, err, full, empty;
    logic [3:0]  idx;
    logic [15:0] busy;
    logic [4:0]  count;
    logic        ack_f, nak_f, err_f, full_f, empty_f;
    logic [3:0]  idx_f;
    logic [15:0] busy_f;
    logic [4:0]  count_f;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        logic        ack, nak, err;
        logic [3:0]  idx;
        logic [15:0] busy;
        logic [4:0]  cnt;
    } exp_t;
    exp_t q[$];
    logic [15:0] m_busy = 16'h0000;
    logic [3:0]  m_idx = 4'd0;

    always #5 clk = ~clk;

    slot_alloc_16 dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .free_req(free_req), .free_idx(free_idx),
        .alloc_ack(ack), .alloc_nak(nak), .alloc_idx(idx), .free_err(err),
        .busy(busy), .count(count), .full(full), .empty(empty)
    );

    slot_alloc_16 #(.INIT_MAP(16'h000F)) dut_f (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .free_req(free_req), .free_idx(free_idx),
        .alloc_ack(ack_f), .alloc_nak(nak_f), .alloc_idx(idx_f), .free_err(err_f),
        .busy(busy_f), .count(count_f), .full(full_f), .empty(empty_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_cycle(input logic req);
        @(negedge clk);
        rst = 1'b1;
        alloc_req = req;
        free_req = req;
        free_idx = 4'd0;
        @(posedge clk);
        #1;
        m_busy = 16'h0000;
        m_idx = 4'd0;
        chk("rst_ack", ack, 0);
        chk("rst_nak", nak, 0);
        chk("rst_err", err, 0);
        chk("rst_idx", idx, 0);
        chk("rst_busy", busy, 16'h0000);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rstf_ack", ack_f, 0);
        chk("rstf_idx", idx_f, 0);
        chk("rstf_busy", busy_f, 16'h000F);
        chk("rstf_count", count_f, 4);
    endtask

    task automatic drive(input logic a, input logic f, input logic [3:0] fi);
        exp_t e;
        logic [3:0]  s;
        logic        fnd;
        logic [15:0] nb;
        logic [4:0]  pc;
        @(negedge clk);
        rst = 1'b0;
        alloc_req = a;
        free_req = f;
        free_idx = fi;
        s = 4'd0;
        fnd = 1'b0;
        for (int i = 0; i < 16; i++)
            if (!fnd && !m_busy[i]) begin
                s = 4'(i);
                fnd = 1'b1;
            end
        e.ack = a && fnd;
        e.nak = a && !fnd;
        e.err = f && !m_busy[fi];
        nb = m_busy;
        if (f && m_busy[fi]) nb[fi] = 1'b0;
        if (e.ack) begin
            nb[s] = 1'b1;
            m_idx = s;
        end
        pc = 5'd0;
        for (int i = 0; i < 16; i++) pc += 5'(nb[i]);
        e.idx = m_idx;
        e.busy = nb;
        e.cnt = pc;
        m_busy = nb;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("ack", ack, e.ack);
        chk("nak", nak, e.nak);
        chk("err", err, e.err);
        if (e.ack) chk("idx", idx, e.idx);
        chk("busy", busy, e.busy);
        chk("count", count, e.cnt);
        chk("full", full, e.cnt == 5'd16);
        chk("empty", empty, e.cnt == 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset_cycle(1'b1);
        reset_cycle(1'b1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 4'd0);
            chk("seq_idx", idx, i);
        end
        chk("fill_busy", busy, 16'hFFFF);
        chk("fill_full", full, 1);
        drive(1'b1, 1'b1, 4'd5);
        chk("fullfree_nak", nak, 1);
        chk("fullfree_ack", ack, 0);
        chk("fullfree_busy", busy, 16'hFFDF);
        chk("fullfree_count", count, 15);
        drive(1'b1, 1'b0, 4'd0);
        chk("refill_idx", idx, 5);
        for (int i = 8; i < 16; i++) drive(1'b0, 1'b1, 4'(i));
        chk("pre_00ff", busy, 16'h00FF);
        drive(1'b1, 1'b1, 4'd3);
        chk("both_idx", idx, 8);
        chk("both_busy", busy, 16'h01F7);
        chk("both_count", count, 8);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 4'(i));
        drive(1'b0, 1'b1, 4'd9);
        chk("empty_err", err, 1);
        chk("empty_count", count, 0);
        chk("empty_busy", busy, 16'h0000);
        drive(1'b0, 1'b0, 4'd0);
        chk("err_clear", err, 0);
        chk("idx_hold", idx, 8);
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 4'd2);
        chk("same_idx", idx, 2);
        chk("same_err", err, 1);
        chk("same_busy", busy, 16'h0007);
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        reset_cycle(1'b1);
        drive(1'b1, 1'b0, 4'd0);
        chk("post_rst_ack_f", ack_f, 1);
        chk("post_rst_idx_f", idx_f, 4);
        chk("post_rst_busy_f", busy_f, 16'h001F);
        chk("post_rst_idx", idx, 0);
        @(negedge clk);
        alloc_req = 1'b0;
        free_req = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
